// File: rtl/matrix_control_pkg.sv
// Shared constants, select encodings and FSM state type for the alignment
// matrix controller and its per-PU decoder.
package design_variables;

  localparam int SEQ_LENGTH   = 32;
  localparam int LETTER_WIDTH = 2;
  localparam int NUM_PU       = 16;
  localparam int NUM_ROWS_PE  = 2;
  localparam int LETTER_SEL_W = $clog2(SEQ_LENGTH);
  localparam int PU_IDX_W     = $clog2(NUM_PU);
  localparam int STEP_W       = 5;

  localparam logic [STEP_W-1:0] LAST_STEP = 5'd30;

  typedef logic [1:0] sel_t;
  typedef logic [LETTER_SEL_W-1:0] letter_sel_t;

  // Score-source encodings: zero, same PU, neighbouring PU, alternate diagonal source
  localparam sel_t SEL_ZERO      = 2'd0;
  localparam sel_t SEL_SAME      = 2'd1;
  localparam sel_t SEL_NEIGHBOUR = 2'd2;
  localparam sel_t SEL_OTHER     = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/matrix_control_if.sv
// Bundle of start/sequence inputs and select/status outputs between the
// alignment controller and whatever drives it.
interface matrix_control_if;
  import design_variables::*;

  logic                                   start;
  logic [SEQ_LENGTH*LETTER_WIDTH-1:0]     query_in;
  logic [SEQ_LENGTH*LETTER_WIDTH-1:0]     database_in;
  logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] query_seq;
  logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] database_seq;
  sel_t [NUM_PU-2:0]                      top_sel;
  sel_t [NUM_PU-2:0]                      left_sel;
  sel_t [NUM_PU-2:0]                      diagonal_sel;
  logic [STEP_W-1:0]                      global_counter;
  letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] query_letter_sel;
  letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] database_letter_sel;
  logic                                   busy;
  logic                                   done;

  modport master (
    output start, query_in, database_in,
    input  query_seq, database_seq, top_sel, left_sel, diagonal_sel,
           global_counter, query_letter_sel, database_letter_sel, busy, done
  );

  modport slave (
    input  start, query_in, database_in,
    output query_seq, database_seq, top_sel, left_sel, diagonal_sel,
           global_counter, query_letter_sel, database_letter_sel, busy, done
  );

endinterface

// File: rtl/matrix_control_pu_sel_decode.sv
// Combinational decode of one PU's score-source selects and letter indices
// for a given anti-diagonal step.
module pu_sel_decode
  import design_variables::*;
(
  input  logic [STEP_W-1:0]                  step,
  input  logic [PU_IDX_W-1:0]                pu_index,
  output sel_t                               top_sel,
  output sel_t                               left_sel,
  output sel_t                               diagonal_sel,
  output letter_sel_t [NUM_ROWS_PE-1:0]      query_letter_sel,
  output letter_sel_t [NUM_ROWS_PE-1:0]      database_letter_sel
);

  // Letter indices are always 2x a value mod 16, so only the low 4 bits of sums matter
  logic [PU_IDX_W-1:0] diff;
  logic [PU_IDX_W-1:0] sum;
  letter_sel_t         query_base;
  letter_sel_t         database_base;

  assign diff = step[PU_IDX_W-1:0] - pu_index;
  assign sum  = step[PU_IDX_W-1:0] + pu_index;

  // step[4] marks the second half of the sweep, where the band slides along the query
  always_comb begin
    query_base    = {pu_index, 1'b0};
    database_base = {diff, 1'b0};
    top_sel       = SEL_SAME;
    left_sel      = SEL_ZERO;
    diagonal_sel  = SEL_ZERO;
    if (step[STEP_W-1]) begin
      query_base    = {sum, 1'b0} - 5'd30;
      database_base = 5'd30 - {pu_index, 1'b0};
      top_sel       = SEL_NEIGHBOUR;
      left_sel      = (pu_index == '0) ? SEL_SAME : SEL_ZERO;
      if (step == 5'd16) begin
        diagonal_sel = SEL_SAME;
      end else begin
        diagonal_sel = (pu_index == '0) ? SEL_NEIGHBOUR : SEL_OTHER;
      end
    end else if (pu_index == '0) begin
      top_sel = (step == '0) ? SEL_ZERO : SEL_SAME;
    end else begin
      left_sel = SEL_SAME;
      if (step == {1'b0, pu_index}) begin
        top_sel      = SEL_ZERO;
        diagonal_sel = SEL_ZERO;
      end else begin
        top_sel      = SEL_SAME;
        diagonal_sel = SEL_NEIGHBOUR;
      end
    end
  end

  assign query_letter_sel[0]    = query_base;
  assign query_letter_sel[1]    = {query_base[LETTER_SEL_W-1:1], 1'b1};
  assign database_letter_sel[0] = database_base;
  assign database_letter_sel[1] = {database_base[LETTER_SEL_W-1:1], 1'b1};

endmodule

// File: rtl/matrix_control.sv
// Sequencer for one 31-step anti-diagonal alignment pass; every output is
// registered from the next-state view so step 0 appears the cycle after start.
module matrix_control
  import design_variables::*;
(
  input  logic             clk,
  input  logic             rst,
  matrix_control_if.slave  bus
);

  state_t            state;
  state_t            next_state;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] next_step;

  sel_t [NUM_PU-1:0]                         dec_top;
  sel_t [NUM_PU-1:0]                         dec_left;
  sel_t [NUM_PU-1:0]                         dec_diag;
  letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] dec_query;
  letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] dec_database;
  logic                                      unused_last_pu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = CALC;
          next_step  = '0;
        end
      end
      CALC: begin
        if (step == LAST_STEP) begin
          next_state = DONE;
          next_step  = '0;
        end else begin
          next_step = step + 5'd1;
        end
      end
      DONE: next_state = IDLE;
      default: begin
        next_state = IDLE;
        next_step  = '0;
      end
    endcase
  end

  // Decoders see the upcoming step so their result lands in the output register on time
  for (genvar g = 0; g < NUM_PU; g++) begin : g_decode
    pu_sel_decode u_decode (
      .step                (next_step),
      .pu_index            (PU_IDX_W'(g)),
      .top_sel             (dec_top[g]),
      .left_sel            (dec_left[g]),
      .diagonal_sel        (dec_diag[g]),
      .query_letter_sel    (dec_query[g]),
      .database_letter_sel (dec_database[g])
    );
  end

  // The last PU has no right-hand neighbour, so its score selects are not exported
  assign unused_last_pu = ^{dec_top[NUM_PU-1], dec_left[NUM_PU-1], dec_diag[NUM_PU-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy                <= 1'b0;
      bus.done                <= 1'b0;
      bus.global_counter      <= '0;
      bus.top_sel             <= '0;
      bus.left_sel            <= '0;
      bus.diagonal_sel        <= '0;
      bus.query_letter_sel    <= '0;
      bus.database_letter_sel <= '0;
      bus.query_seq           <= '0;
      bus.database_seq        <= '0;
    end else begin
      bus.busy <= (next_state != IDLE);
      bus.done <= (next_state == DONE);
      if (next_state == CALC) begin
        bus.global_counter      <= next_step + 5'd1;
        bus.top_sel             <= dec_top[NUM_PU-2:0];
        bus.left_sel            <= dec_left[NUM_PU-2:0];
        bus.diagonal_sel        <= dec_diag[NUM_PU-2:0];
        bus.query_letter_sel    <= dec_query;
        bus.database_letter_sel <= dec_database;
      end else begin
        bus.global_counter      <= '0;
        bus.top_sel             <= '0;
        bus.left_sel            <= '0;
        bus.diagonal_sel        <= '0;
        bus.query_letter_sel    <= '0;
        bus.database_letter_sel <= '0;
      end
      if (state == IDLE && bus.start) begin
        bus.query_seq    <= bus.query_in;
        bus.database_seq <= bus.database_in;
      end
    end
  end

endmodule

// File: tb/tb_matrix_control.sv
// Directed bench for matrix_control: a reference model fills a scoreboard
// with per-step expectations that are popped as the controller steps.
module tb_matrix_control;
  import design_variables::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  matrix_control_if bus ();

  matrix_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [STEP_W-1:0]                         gc;
    sel_t [NUM_PU-2:0]                         top;
    sel_t [NUM_PU-2:0]                         left;
    sel_t [NUM_PU-2:0]                         diag;
    letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] qs;
    letter_sel_t [NUM_PU-1:0][NUM_ROWS_PE-1:0] ds;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [SEQ_LENGTH*LETTER_WIDTH-1:0] exp_query;
  logic [SEQ_LENGTH*LETTER_WIDTH-1:0] exp_database;

  task automatic check_output(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference values written straight from the step/PU arithmetic using plain integers
  function automatic exp_t model_step(input int i);
    exp_t e;
    int   q0;
    int   d0;
    e    = '0;
    e.gc = 5'(i + 1);
    for (int j = 0; j < NUM_PU; j++) begin
      if (i < 16) begin
        q0 = 2 * j;
        d0 = 2 * (i - j);
      end else begin
        q0 = 2 * (i + j) - 30;
        d0 = 30 - 2 * j;
      end
      e.qs[j][0] = 5'(q0 & 31);
      e.qs[j][1] = 5'((q0 + 1) & 31);
      e.ds[j][0] = 5'(d0 & 31);
      e.ds[j][1] = 5'((d0 + 1) & 31);
    end
    for (int k = 0; k < NUM_PU - 1; k++) begin
      if (i < 16) begin
        if (k == 0) begin
          e.top[k]  = (i == 0) ? 2'd0 : 2'd1;
          e.left[k] = 2'd0;
          e.diag[k] = 2'd0;
        end else begin
          e.left[k] = 2'd1;
          e.top[k]  = (i == k) ? 2'd0 : 2'd1;
          e.diag[k] = (i == k) ? 2'd0 : 2'd2;
        end
      end else begin
        e.top[k]  = 2'd2;
        e.left[k] = (k == 0) ? 2'd1 : 2'd0;
        e.diag[k] = (i == 16) ? 2'd1 : ((k == 0) ? 2'd2 : 2'd3);
      end
    end
    return e;
  endfunction

  task automatic push_pass();
    for (int i = 0; i <= 30; i++) exp_q.push_back(model_step(i));
  endtask

  task automatic apply_stimulus(input bit hold_start);
    @(negedge clk);
    exp_query        = {$urandom, $urandom};
    exp_database     = {$urandom, $urandom};
    bus.query_in     = exp_query;
    bus.database_in  = exp_database;
    bus.start        = 1'b1;
    push_pass();
    if (!hold_start) begin
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_done"}, bus.done, 0);
    check_output({tag, "_gc"}, bus.global_counter, 0);
    check_output({tag, "_top"}, bus.top_sel, 0);
    check_output({tag, "_left"}, bus.left_sel, 0);
    check_output({tag, "_diag"}, bus.diagonal_sel, 0);
    check_output({tag, "_qsel"}, bus.query_letter_sel, 0);
    check_output({tag, "_dsel"}, bus.database_letter_sel, 0);
  endtask

  task automatic monitor_pass(input int n_steps, input int pulse_at);
    exp_t e;
    for (int s = 0; s < n_steps; s++) begin
      @(negedge clk);
      check_output("calc_busy", bus.busy, 1);
      check_output("calc_done", bus.done, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty step=%0d observed_gc=%0d", s, bus.global_counter);
      end else begin
        e = exp_q.pop_front();
        check_output("gc", bus.global_counter, e.gc);
        check_output("top_sel", bus.top_sel, e.top);
        check_output("left_sel", bus.left_sel, e.left);
        check_output("diagonal_sel", bus.diagonal_sel, e.diag);
        check_output("query_letter_sel", bus.query_letter_sel, e.qs);
        check_output("database_letter_sel", bus.database_letter_sel, e.ds);
      end
      if (s == 0) begin
        check_output("s0_gc", bus.global_counter, 1);
        check_output("s0_top0", bus.top_sel[0], 0);
        check_output("s0_q3_1", bus.query_letter_sel[3][1], 7);
        check_output("s0_d0_0", bus.database_letter_sel[0][0], 0);
      end
      if (s == 5) begin
        check_output("s5_top5", bus.top_sel[5], 0);
        check_output("s5_diag5", bus.diagonal_sel[5], 0);
        check_output("s5_left5", bus.left_sel[5], 1);
        check_output("s5_top6", bus.top_sel[6], 1);
        check_output("s5_diag6", bus.diagonal_sel[6], 2);
        check_output("s5_d2", bus.database_letter_sel[2], {5'd7, 5'd6});
      end
      if (s == 16) begin
        check_output("s16_top", bus.top_sel, {15{2'b10}});
        check_output("s16_left", bus.left_sel, 30'd1);
        check_output("s16_diag", bus.diagonal_sel, {15{2'b01}});
        check_output("s16_q0", bus.query_letter_sel[0], {5'd3, 5'd2});
        check_output("s16_d0", bus.database_letter_sel[0], {5'd31, 5'd30});
      end
      if (s == 17) begin
        check_output("s17_diag", bus.diagonal_sel, {{14{2'b11}}, 2'b10});
      end
      if (pulse_at >= 0) bus.start = (s == pulse_at);
    end
  endtask

  task automatic check_tail();
    @(negedge clk);
    check_output("tail_done", bus.done, 1);
    check_output("tail_busy", bus.busy, 1);
    check_output("tail_gc", bus.global_counter, 0);
    check_output("tail_top", bus.top_sel, 0);
    check_output("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check_idle_zero("after_done");
    check_output("held_query_seq", bus.query_seq, exp_query);
    check_output("held_database_seq", bus.database_seq, exp_database);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.query_in    = '0;
    bus.database_in = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    check_output("reset_query_seq", bus.query_seq, 0);
    check_output("reset_database_seq", bus.database_seq, 0);

    bus.start    = 1'b1;
    bus.query_in = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    check_output("rst_priority_busy", bus.busy, 0);
    check_output("rst_priority_query_seq", bus.query_seq, 0);
    rst       = 1'b0;
    bus.start = 1'b0;

    $display("[TB] pass with start pulsed mid-calculation");
    apply_stimulus(1'b0);
    monitor_pass(31, 8);
    check_tail();

    $display("[TB] pass aborted by reset at step 10");
    apply_stimulus(1'b0);
    monitor_pass(11, -1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("abort");
    check_output("abort_query_seq", bus.query_seq, 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_no_done", bus.done, 0);
    check_output("abort_idle_busy", bus.busy, 0);

    $display("[TB] fresh pass after abort");
    apply_stimulus(1'b0);
    monitor_pass(31, -1);
    check_tail();

    $display("[TB] start held high across two passes");
    apply_stimulus(1'b1);
    monitor_pass(31, -1);
    check_tail();
    push_pass();
    monitor_pass(31, -1);
    bus.start = 1'b0;
    check_tail();
    @(negedge clk);
    check_output("final_idle_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_control.md
MATRIX_CONTROL -- requirements
Module: matrix_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin one alignment pass; sampled only in IDLE.
REQ-005 query_in  in  SEQ_LENGTH*LETTER_WIDTH  query sequence, captured on accepted start.
REQ-006 database_in  in  SEQ_LENGTH*LETTER_WIDTH  database sequence, captured on accepted start.
REQ-007 query_seq, database_seq  out  SEQ_LENGTH x LETTER_WIDTH each  captured sequences, held stable until the next accepted start.
REQ-008 top_sel, left_sel, diagonal_sel  out  (NUM_PU-1) x 2 each  per-PU score-source selects for matrix_calculation.
REQ-009 global_counter  out  5  diagonal step index (step+1) during CALC; 0 otherwise.
REQ-010 query_letter_sel, database_letter_sel  out  NUM_PU x NUM_ROWS_PE x log2(SEQ_LENGTH)  per-PE letter indices.
REQ-011 busy  out  1  high in CALC and DONE; done  out  1  one-cycle pulse in DONE.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE when step=30, DONE->IDLE unconditionally.
REQ-013 Start accepted at edge N SHALL give CALC with step 0 outputs in cycle N+1; step increments by 1 per cycle for exactly 31 cycles (0..30).
REQ-014 start while busy SHALL be ignored; start held high in DONE SHALL not be accepted until IDLE (minimum 33 cycles between accepted starts).
REQ-015 All outputs SHALL be registered; no combinational path from start to any output.
REQ-016 Letter selects, step i, PU j, step<16: query[j][0]=2j, query[j][1]=2j+1, database[j][0]=2(i-j), database[j][1]=2(i-j)+1, truncated to 5 bits (negative values wrap).
REQ-017 Letter selects, step>=16: query[j][0]=2(i+j)-30, query[j][1]=2(i+j)-29, database[j][0]=30-2j, database[j][1]=31-2j, truncated to 5 bits.
REQ-018 Score selects, k=0..NUM_PU-2, step<16: k=0: top=(i=0)?0:1, left=0, diag=0; k>0: left=1, (i=k)?top=0,diag=0 : top=1,diag=2.
REQ-019 Score selects, step>=16: top=2; left=(k=0)?1:0; diag=(i=16)?1:((k=0)?2:3).
REQ-020 Outside CALC, all select and counter outputs SHALL be 0.
REQ-021 done SHALL be 1 only in DONE, and high for exactly one cycle per pass.

Reset
REQ-022 rst high at a rising edge SHALL force IDLE, step=0, all select/counter outputs 0, busy=0, done=0, query_seq/database_seq=0.
REQ-023 Reset mid-CALC SHALL abort the pass with no done pulse; the next start after release begins a fresh pass at step 0.
REQ-024 rst and start both high SHALL give reset priority; start is not accepted.

Structure
REQ-025 SEQ_LENGTH=32, LETTER_WIDTH=2, NUM_PU=16, NUM_ROWS_PE=2, the 2-bit select encodings (top: 0 zero, 1 same-PU, 2 neighbour; diag: 0..3) and the FSM state enum SHALL come from the shared design_variables package.
REQ-026 Per-PU decode of REQ-016..019 SHALL be one combinational sub-module, pu_sel_decode (inputs step, PU index), instantiated NUM_PU times, with outputs registered in matrix_control.

Verification
REQ-027 Reset, then start=1 one cycle -> cycle+1 busy=1, global_counter=1, top_sel[0]=0, query_letter_sel[3][1]=7, database_letter_sel[0][0]=0.
REQ-028 Step 5 -> top_sel[5]=0, diagonal_sel[5]=0, left_sel[5]=1, top_sel[6]=1, diagonal_sel[6]=2, database_letter_sel[2]={6,7}.
REQ-029 Step 16 -> top_sel all 2, left_sel[0]=1, left_sel[1..14]=0, diagonal_sel all 1, query_letter_sel[0]={2,3}, database_letter_sel[0]={30,31}; step 17 -> diagonal_sel[0]=2, others 3.
REQ-030 Step 30 (global_counter=31) -> next cycle done=1 for one cycle, then busy=0, all selects 0; query_seq still holds captured value.
REQ-031 rst=1 at step 10 -> next cycle all outputs 0, no done pulse; start then runs full 31-step pass.
REQ-032 start held high continuously -> passes begin every 33 cycles; start pulsed during CALC -> no effect on step sequence.
